mips_datapath_core: RTL and testbench
=====================================

Name: mips_datapath_core

Overview:
- Single-cycle MIPS-style datapath: PC register, next-PC logic (sequential, branch, jump), 32x32 register file, sign extender, ALU operand mux and write-back muxes.
- Control signals come from an external controller.
- Instruction bits [25:0] arrive on `inst_field`. Data memory sits outside the block and is reached through `ALU_out` (address), `Data_out` (store data) and `Data_in` (load data).

Parameters:
- `RESET_PC`, 32'h0000_0000, PC value loaded on reset.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `Jump`  in  1  select jump target for next PC.
- `Branch`  in  1  conditional branch enable; taken when ALU zero = 1.
- `ALU_Control`  in  3  ALU operation select.
- `ALUSrc_B`  in  1  0: ALU B = rt data; 1: ALU B = sign-extended immediate.
- `RegWrite`  in  1  register file write enable.
- `inst_field`  in  26  instruction bits [25:0].
- `Data_in`  in  32  load data from data memory.
- `MemtoReg`  in  1  0: write back `ALU_out`; 1: write back `Data_in`.
- `RegDst`  in  1  0: destination = rt; 1: destination = rd.
- `PC_out`  out  32  current PC.
- `Data_out`  out  32  rt read data (store data).
- `ALU_out`  out  32  ALU result (combinational).

Behaviour:
- Instruction field decode:
  - rs = `inst_field[25:21]`, rt = [20:16], rd = [15:11].
  - imm = [15:0]; `SignExt` = {{16{imm[15]}}, imm}.
- Reset: while `rst` = 1, asynchronously PC = `RESET_PC` and all 32 registers = 0. Reset overrides any write in the same cycle. `PC_out` = 0 during reset.
- Register file:
  - Two combinational read ports (rs → A, rt → `Data_out`).
  - One write port on the rising edge of `clk` when `RegWrite` = 1.
  - Write address = `RegDst` ? rd : rt. Write data = `MemtoReg` ? `Data_in` : `ALU_out`.
  - Register 0 always reads 0; writes to it are discarded.
  - Read in the same cycle as a write returns the old value; the new value is visible after the edge.
- ALU: A = rs data; B = `ALUSrc_B` ? `SignExt` : rt data. Operations by `ALU_Control`:
  - 000 AND; 001 OR; 010 ADD (mod 2^32, no overflow trap); 011 XOR.
  - 100 NOR; 101 SRL (B >> A[4:0], logical); 110 SUB (A−B mod 2^32).
  - 111 SLT (signed A<B → 32'h1, else 0).
  - zero = (`ALU_out` == 0).
- Next PC, updated every rising edge when `rst` = 0:
  - PC4 = PC + 4.
  - Branch target = PC4 + (`SignExt` << 2).
  - Jump target = {PC4[31:28], `inst_field`, 2'b00}.
  - Priority: `Jump` = 1 → jump target; else (`Branch` & zero) → branch target; else PC4.
- Latency: `PC_out` and register contents change only on the clock edge. `ALU_out`, `Data_out` and zero follow inputs combinationally in the same cycle.
- Reset asserted mid-cycle: PC and registers clear immediately. The first edge after deassertion loads a PC computed from `RESET_PC`.
- Unknown or unused `ALU_Control` values: none, all 8 codes are defined.

Test Plan:
- Reset:
  - Stimulus: `rst` = 1 for one cycle, all controls 0.
  - Required: `PC_out` = 0; `ALU_out` = 0 (r0 AND r0); `Data_out` = 0.
  - Release `rst`: `PC_out` = 4, 8, 12 on successive edges.
- Jump:
  - Stimulus: after reset (PC = 0), `Jump` = 1, `inst_field` = 26'h113B7E0, one edge.
  - Required: `PC_out` = 32'h044EDF80. `Jump` = 0 next cycle → 32'h044EDF84.
- Load write-back:
  - Write: `RegWrite` = 1, `RegDst` = 1, `MemtoReg` = 1, `Data_in` = 32'h12345678, rd = 5, one edge.
  - Read back: `RegWrite` = 0, rs = 5, `ALUSrc_B` = 1, imm = 0, `ALU_Control` = 010.
  - Required: `ALU_out` = 32'h12345678. Same data with rt = 5 → `Data_out` = 32'h12345678.
- ALU ops (r1 = 7, r2 = 32'hFFFFFFFE via ADDI-style write-backs):
  - SUB r1−r2 = 9; SLT r2<r1 = 1; AND = 6; OR = 32'hFFFFFFFF; NOR = 0; XOR = 32'hFFFFFFF9.
- Branch: rs = rt = 0, `ALU_Control` = 110, `Branch` = 1, imm = 16'h0003, PC = 8 → next PC = 24.
  - imm = 16'hFFFF → next PC = PC.
  - rs ≠ rt (nonzero diff) → PC + 4.
- r0 protection and async reset:
  - Write 32'hDEADBEEF to r0 → reading r0 gives 0.
  - Pulse `rst` between edges → `PC_out` and registers clear immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/mips_datapath_core.sv
// Single-cycle MIPS-style datapath: PC, next-PC select, 32x32 register file, sign extend, ALU, write-back muxes.
// Latency: ALU_out/Data_out combinational in the current cycle; PC and registers update on the rising clk edge.
// Backpressure: none; the datapath advances one instruction every cycle unless rst is high.
module mips_datapath_core #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        Jump,
    input  logic        Branch,
    input  logic [2:0]  ALU_Control,
    input  logic        ALUSrc_B,
    input  logic        RegWrite,
    input  logic [25:0] inst_field,
    input  logic [31:0] Data_in,
    input  logic        MemtoReg,
    input  logic        RegDst,
    output logic [31:0] PC_out,
    output logic [31:0] Data_out,
    output logic [31:0] ALU_out
);

    logic [31:0] pc_q, pc_d;
    logic [31:0] regs_q [32];
    logic [31:0] regs_d [32];

    logic [4:0]  rs_addr, rt_addr, rd_addr, wr_addr;
    logic [15:0] imm;
    logic [31:0] sign_ext, rs_data, rt_data, alu_b, wr_data;
    logic [31:0] pc4, branch_target, jump_target;
    logic        alu_zero;

    assign rs_addr  = inst_field[25:21];
    assign rt_addr  = inst_field[20:16];
    assign rd_addr  = inst_field[15:11];
    assign imm      = inst_field[15:0];
    assign sign_ext = {{16{imm[15]}}, imm};

    // Register read ports; r0 is hard-wired to zero regardless of storage.
    always_comb begin
        rs_data = (rs_addr == 5'd0) ? 32'h0 : regs_q[rs_addr];
        rt_data = (rt_addr == 5'd0) ? 32'h0 : regs_q[rt_addr];
    end

    assign alu_b    = ALUSrc_B ? sign_ext : rt_data;
    assign Data_out = rt_data;

    // ALU: operation chosen directly by ALU_Control; all eight codes are defined.
    always_comb begin
        ALU_out = 32'h0;
        unique case (ALU_Control)
            3'b000: ALU_out = rs_data & alu_b;
            3'b001: ALU_out = rs_data | alu_b;
            3'b010: ALU_out = rs_data + alu_b;
            3'b011: ALU_out = rs_data ^ alu_b;
            3'b100: ALU_out = ~(rs_data | alu_b);
            3'b101: ALU_out = alu_b >> rs_data[4:0];
            3'b110: ALU_out = rs_data - alu_b;
            3'b111: ALU_out = ($signed(rs_data) < $signed(alu_b)) ? 32'h1 : 32'h0;
            default: ALU_out = 32'h0;
        endcase
    end

    assign alu_zero = (ALU_out == 32'h0);

    // Next-PC selection: jump has priority over a taken branch, otherwise fall through.
    always_comb begin
        pc4           = pc_q + 32'd4;
        branch_target = pc4 + {sign_ext[29:0], 2'b00};
        jump_target   = {pc4[31:28], inst_field, 2'b00};
        pc_d          = pc4;
        if (Jump) begin
            pc_d = jump_target;
        end else if (Branch && alu_zero) begin
            pc_d = branch_target;
        end
    end

    // Write-back: destination and source muxes; writes to r0 are dropped.
    always_comb begin
        wr_addr = RegDst ? rd_addr : rt_addr;
        wr_data = MemtoReg ? Data_in : ALU_out;
        regs_d  = regs_q;
        if (RegWrite && (wr_addr != 5'd0)) begin
            regs_d[wr_addr] = wr_data;
        end
    end

    // PC register; async reset reloads the reset vector.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    // Register file storage; async reset clears every entry and beats any pending write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= 32'h0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    assign PC_out = pc_q;

endmodule

// File: tb/tb_mips_datapath_core.sv
module tb_mips_datapath_core;

    logic        clk = 1'b0;
    logic        rst;
    logic        Jump, Branch, ALUSrc_B, RegWrite, MemtoReg, RegDst;
    logic [2:0]  ALU_Control;
    logic [25:0] inst_field;
    logic [31:0] Data_in;
    logic [31:0] PC_out, Data_out, ALU_out;

    int tests = 0;
    int fails = 0;

    // Reference state: architectural registers and PC.
    logic [31:0] mregs [32];
    logic [31:0] mpc;

    mips_datapath_core dut (
        .clk(clk), .rst(rst), .Jump(Jump), .Branch(Branch),
        .ALU_Control(ALU_Control), .ALUSrc_B(ALUSrc_B), .RegWrite(RegWrite),
        .inst_field(inst_field), .Data_in(Data_in), .MemtoReg(MemtoReg),
        .RegDst(RegDst), .PC_out(PC_out), .Data_out(Data_out), .ALU_out(ALU_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [25:0] fld(input int rs, input int rt, input logic [15:0] imm);
        logic [4:0] a, b;
        a = rs[4:0];
        b = rt[4:0];
        return {a, b, imm};
    endfunction

    function automatic logic [31:0] sext(input logic [25:0] f);
        int v;
        v = int'(f[15:0]);
        if (v >= 32768) v = v - 65536;
        return 32'(v);
    endfunction

    function automatic logic [31:0] model_alu();
        logic [31:0] a, b;
        a = mregs[inst_field[25:21]];
        b = ALUSrc_B ? sext(inst_field) : mregs[inst_field[20:16]];
        case (ALU_Control)
            3'd0: return a & b;
            3'd1: return a | b;
            3'd2: return 32'(longint'(a) + longint'(b));
            3'd3: return a ^ b;
            3'd4: return ~(a | b);
            3'd5: return b / (32'd1 << (a % 32));
            3'd6: return 32'(longint'(a) - longint'(b));
            default: return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) mregs[i] = 32'h0;
        mpc = 32'h0;
    endtask

    task automatic drive(input logic j, input logic b, input logic [2:0] op, input logic srcb,
                         input logic rw, input logic dst, input logic m2r,
                         input logic [25:0] f, input logic [31:0] din);
        Jump = j; Branch = b; ALU_Control = op; ALUSrc_B = srcb;
        RegWrite = rw; RegDst = dst; MemtoReg = m2r; inst_field = f; Data_in = din;
    endtask

    // Check combinational outputs against the model for the current inputs.
    task automatic settle();
        #1;
        chk("alu_out", ALU_out, model_alu());
        chk("data_out", Data_out, mregs[inst_field[20:16]]);
    endtask

    // One clock edge: predict architectural effect, then compare PC.
    task automatic tick();
        logic [31:0] alu, pc4, npc, wd;
        int wa;
        alu = model_alu();
        pc4 = mpc + 32'd4;
        if (Jump) npc = {pc4[31:28], inst_field, 2'b00};
        else if (Branch && alu == 32'h0) npc = pc4 + sext(inst_field) * 4;
        else npc = pc4;
        wa = RegDst ? int'(inst_field[15:11]) : int'(inst_field[20:16]);
        wd = MemtoReg ? Data_in : alu;
        @(posedge clk);
        #1;
        mpc = npc;
        if (RegWrite && wa != 0) mregs[wa] = wd;
        chk("pc", PC_out, mpc);
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        #2;
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        model_reset();
        rst = 1'b1;
        drive(0, 0, 3'd0, 0, 0, 0, 0, 26'h0, 32'h0);
        #12;
        chk("rst_pc", PC_out, 32'h0);
        chk("rst_alu", ALU_out, 32'h0);
        chk("rst_dout", Data_out, 32'h0);
        rst = 1'b0;
        tick(); chk("seq4", PC_out, 32'd4);
        tick(); chk("seq8", PC_out, 32'd8);
        tick(); chk("seq12", PC_out, 32'd12);

        // Jump from PC 0
        pulse_reset();
        drive(1, 0, 3'd0, 0, 0, 0, 0, 26'h113B7E0, 32'h0);
        tick(); chk("jump", PC_out, 32'h044EDF80);
        Jump = 1'b0;
        tick(); chk("jump_next", PC_out, 32'h044EDF84);

        // Load write-back into r5 via rd, then read back on both ports
        drive(0, 0, 3'd0, 0, 1, 1, 1, fld(0, 0, 16'(5 << 11)), 32'h12345678);
        settle();
        tick();
        drive(0, 0, 3'd2, 1, 0, 0, 0, fld(5, 5, 16'h0), 32'h0);
        settle();
        chk("load_alu", ALU_out, 32'h12345678);
        chk("load_dout", Data_out, 32'h12345678);

        // r1 = 7, r2 = -2 via immediate adds; branch tests need PC 8 afterwards
        pulse_reset();
        drive(0, 0, 3'd2, 1, 1, 0, 0, fld(0, 1, 16'd7), 32'h0);
        tick();
        drive(0, 0, 3'd2, 1, 1, 0, 0, fld(0, 2, 16'hFFFE), 32'h0);
        tick();
        chk("pc_before_br", PC_out, 32'd8);
        RegWrite = 1'b0; ALUSrc_B = 1'b0; inst_field = fld(1, 2, 16'h0);
        ALU_Control = 3'd6; settle(); chk("sub", ALU_out, 32'd9);
        ALU_Control = 3'd0; settle(); chk("and", ALU_out, 32'd6);
        ALU_Control = 3'd1; settle(); chk("or", ALU_out, 32'hFFFFFFFF);
        ALU_Control = 3'd4; settle(); chk("nor", ALU_out, 32'h0);
        ALU_Control = 3'd3; settle(); chk("xor", ALU_out, 32'hFFFFFFF9);
        inst_field = fld(2, 1, 16'h0);
        ALU_Control = 3'd7; settle(); chk("slt", ALU_out, 32'd1);

        // Branches
        drive(0, 1, 3'd6, 0, 0, 0, 0, fld(0, 0, 16'h0003), 32'h0);
        tick(); chk("br_taken", PC_out, 32'd24);
        inst_field = fld(0, 0, 16'hFFFF);
        tick(); chk("br_self", PC_out, 32'd24);
        inst_field = fld(1, 2, 16'h0003);
        tick(); chk("br_not", PC_out, 32'd28);

        // r0 protection
        drive(0, 0, 3'd0, 0, 1, 0, 1, fld(0, 0, 16'h0), 32'hDEADBEEF);
        tick();
        drive(0, 0, 3'd2, 1, 0, 0, 0, fld(0, 0, 16'h0), 32'h0);
        settle();
        chk("r0_alu", ALU_out, 32'h0);
        chk("r0_dout", Data_out, 32'h0);

        // Async reset between edges clears PC and registers at once
        drive(0, 0, 3'd2, 1, 0, 0, 0, fld(1, 2, 16'h0), 32'h0);
        #1;
        chk("pre_rst_r1", ALU_out, 32'd7);
        rst = 1'b1;
        #1;
        chk("async_pc", PC_out, 32'h0);
        chk("async_r1", ALU_out, 32'h0);
        chk("async_r2", Data_out, 32'h0);
        rst = 1'b0;
        model_reset();
        tick(); chk("post_rst_pc", PC_out, 32'd4);

        // Randomized instruction stream against the model
        for (int n = 0; n < 400; n++) begin
            drive(($urandom_range(0, 15) == 0), $urandom_range(0, 1), 3'($urandom_range(0, 7)),
                  $urandom_range(0, 1), ($urandom_range(0, 3) != 0), $urandom_range(0, 1),
                  $urandom_range(0, 1), 26'($urandom), $urandom);
            if ($urandom_range(0, 3) == 0)
                inst_field[20:16] = inst_field[25:21];
            settle();
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

endmodule
